array_18_ctrl: RTL

- Access controller sitting directly upstream of the 4096x160 single-port, lane-masked SRAM macro (RW0 port); it is the only driver of that macro.
- Converts a valid/ready request stream into macro read/write cycles and captures read data one cycle after the read enable.
- Buffers read responses in a small queue so consumer backpressure is supported.
- Runs a zero-initialisation sweep of the whole array after reset.

---
 rtl/array_18_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/array_18_ctrl.sv
// array_18_ctrl: sole access controller for a 4096x160 lane-masked SRAM (RW0).
// Ports: clock/reset_n, req_* (valid/ready request in), resp_* (read data out), init_done, RW0_* (macro).
module array_18_ctrl #(
  parameter int ADDR_W        = 12,
  parameter int LANES         = 10,
  parameter int LANE_W        = 16,
  parameter int RESP_DEPTH    = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LANES-1:0]          req_wmask,
  input  logic [LANES*LANE_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [LANES*LANE_W-1:0]   resp_data,
  output logic                      init_done,
  output logic [ADDR_W-1:0]         RW0_addr,
  output logic                      RW0_en,
  output logic                      RW0_wmode,
  output logic [LANES-1:0]          RW0_wmask,
  output logic [LANES*LANE_W-1:0]   RW0_wdata,
  input  logic [LANES*LANE_W-1:0]   RW0_rdata
);

  localparam int DW = LANES * LANE_W;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OW = $clog2(RESP_DEPTH + 2) + 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_done;
  logic              r_inflight;
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [OW-1:0]     r_occ;
  logic [DW-1:0]     r_q [RESP_DEPTH];

  logic              w_sweep;
  logic              w_acc;
  logic              w_pop;
  logic              w_push;
  logic [OW-1:0]     w_used;
  logic [OW-1:0]     w_lim;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The inflight read already owns a queue slot, so it counts
  // against capacity; a same-cycle pop frees one.
  always_comb begin
    w_sweep    = reset_n && (r_state == S_INIT);
    resp_valid = reset_n && (r_occ != '0);
    resp_data  = r_q[r_rd];
    w_pop      = resp_valid && resp_ready;
    w_push     = r_inflight;
    w_used     = r_occ + OW'(r_inflight);
    w_lim      = OW'(RESP_DEPTH) + OW'(w_pop);
    req_ready  = reset_n && r_done && (w_used < w_lim);
    w_acc      = req_valid && req_ready;
    init_done  = reset_n && r_done;
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    unique case (1'b1)
      w_sweep: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = r_cnt;
        RW0_wmask = '1;
      end
      w_acc: begin
        RW0_en    = 1'b1;
        RW0_wmode = req_write;
        RW0_addr  = req_addr;
        RW0_wmask = req_wmask;
        RW0_wdata = req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_occ      <= '0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= S_RUN;
            r_done  <= 1'b1;
          end
        end
        S_RUN: r_done <= 1'b1;
        default: r_state <= S_RUN;
      endcase
      r_inflight <= w_acc && !req_write;
      if (w_push) r_wr <= f_nxt(r_wr);
      if (w_pop)  r_rd <= f_nxt(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Read data is only valid the cycle after the read enable.
  always_ff @(posedge clock) begin
    if (reset_n && r_inflight) r_q[r_wr] <= RW0_rdata;
  end

endmodule
